// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Detects load-use hazards against the instruction in EX, inserts bubbles on
// stall or flush, and builds the ALU operands through the EX forwarding muxes.
module id_ex_stage #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned REG_SIZE    = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   id_valid,
  input  logic [DATA_WIDTH-1:0]  id_pc,
  input  logic [DATA_WIDTH-1:0]  id_imm,
  input  logic [REG_SIZE-1:0]    id_rs1,
  input  logic [REG_SIZE-1:0]    id_rs2,
  input  logic [REG_SIZE-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]  id_rs1_data,
  input  logic [DATA_WIDTH-1:0]  id_rs2_data,
  input  logic                   id_regWrite,
  input  logic                   id_memRead,
  input  logic                   id_memWrite,
  input  logic                   id_aluSrc,
  input  logic [3:0]             id_aluOp,
  input  logic                   flush,
  input  logic [1:0]             df_mux1,
  input  logic [1:0]             df_mux2,
  input  logic [DATA_WIDTH-1:0]  mem_aluResult,
  input  logic [DATA_WIDTH-1:0]  wb_writeData,
  output logic                   ex_valid,
  output logic                   ex_regWrite,
  output logic                   ex_memRead,
  output logic                   ex_memWrite,
  output logic                   ex_aluSrc,
  output logic [3:0]             ex_aluOp,
  output logic [REG_SIZE-1:0]    ex_rs1,
  output logic [REG_SIZE-1:0]    ex_rs2,
  output logic [REG_SIZE-1:0]    ex_rd,
  output logic [DATA_WIDTH-1:0]  ex_pc,
  output logic [DATA_WIDTH-1:0]  ex_imm,
  output logic [DATA_WIDTH-1:0]  ex_opA,
  output logic [DATA_WIDTH-1:0]  ex_opB,
  output logic [DATA_WIDTH-1:0]  ex_storeData,
  output logic                   stall,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic                   valid_q, reg_write_q, mem_read_q, mem_write_q, alu_src_q;
  logic [3:0]             alu_op_q;
  logic [REG_SIZE-1:0]    rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0]  pc_q, imm_q, rs1_data_q, rs2_data_q;
  logic [STALL_CNT_W-1:0] stall_count_q;
  logic                   hazard;
  logic [DATA_WIDTH-1:0]  fwd1, fwd2;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    hazard = id_valid & valid_q & mem_read_q & (rd_q != '0) &
             ((rd_q == id_rs1) | (rd_q == id_rs2));
    // A flushed ID instruction is wrong-path, so it must not hold the front end.
    stall  = hazard & ~flush;
  end

  // Pipeline register: bubble on flush/hazard, otherwise capture ID.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
    end else if (flush || hazard) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
    end else begin
      // Controls and indices of an invalid slot are zeroed so they never
      // trigger forwarding or hazards downstream.
      valid_q     <= id_valid;
      reg_write_q <= id_valid & id_regWrite;
      mem_read_q  <= id_valid & id_memRead;
      mem_write_q <= id_valid & id_memWrite;
      alu_src_q   <= id_valid & id_aluSrc;
      alu_op_q    <= id_valid ? id_aluOp : '0;
      rs1_q       <= id_valid ? id_rs1 : '0;
      rs2_q       <= id_valid ? id_rs2 : '0;
      rd_q        <= id_valid ? id_rd : '0;
      pc_q        <= id_pc;
      imm_q       <= id_imm;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
    end
  end

  // Saturating count of load-use stalls; only reset clears it.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stall_count_q <= '0;
    end else if (stall && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + 1'b1;
    end
  end

  // Forwarding muxes; the illegal select 11 falls back to the register value.
  always_comb begin
    case (df_mux1)
      2'b01:   fwd1 = mem_aluResult;
      2'b10:   fwd1 = wb_writeData;
      default: fwd1 = rs1_data_q;
    endcase
    case (df_mux2)
      2'b01:   fwd2 = mem_aluResult;
      2'b10:   fwd2 = wb_writeData;
      default: fwd2 = rs2_data_q;
    endcase
  end

  // Output drive: operands and registered fields.
  always_comb begin
    ex_opA       = fwd1;
    ex_opB       = alu_src_q ? imm_q : fwd2;
    ex_storeData = fwd2;
    ex_valid     = valid_q;
    ex_regWrite  = reg_write_q;
    ex_memRead   = mem_read_q;
    ex_memWrite  = mem_write_q;
    ex_aluSrc    = alu_src_q;
    ex_aluOp     = alu_op_q;
    ex_rs1       = rs1_q;
    ex_rs2       = rs2_q;
    ex_rd        = rd_q;
    ex_pc        = pc_q;
    ex_imm       = imm_q;
    stall_count  = stall_count_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the EX slot.
module tb_id_ex_stage;

  localparam int unsigned DW     = 32;
  localparam int unsigned RW     = 5;
  localparam int unsigned CW     = 4;
  localparam int unsigned CNTMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstN;
  logic          id_valid, id_regWrite, id_memRead, id_memWrite, id_aluSrc, flush;
  logic [DW-1:0] id_pc, id_imm, id_rs1_data, id_rs2_data, mem_aluResult, wb_writeData;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;
  logic [3:0]    id_aluOp;
  logic [1:0]    df_mux1, df_mux2;
  logic          ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, stall;
  logic [3:0]    ex_aluOp;
  logic [RW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [DW-1:0] ex_pc, ex_imm, ex_opA, ex_opB, ex_storeData;
  logic [CW-1:0] stall_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Model of the instruction slot currently sitting in EX.
  int unsigned m_valid, m_regWrite, m_memRead, m_memWrite, m_aluSrc, m_aluOp;
  int unsigned m_rs1, m_rs2, m_rd, m_pc, m_imm, m_d1, m_d2, m_count;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(DW), .REG_SIZE(RW), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rstN(rstN), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
    .id_memWrite(id_memWrite), .id_aluSrc(id_aluSrc), .id_aluOp(id_aluOp),
    .flush(flush), .df_mux1(df_mux1), .df_mux2(df_mux2),
    .mem_aluResult(mem_aluResult), .wb_writeData(wb_writeData),
    .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_aluSrc(ex_aluSrc), .ex_aluOp(ex_aluOp),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_storeData(ex_storeData),
    .stall(stall), .stall_count(stall_count)
  );

  task automatic model_reset();
    {m_valid, m_regWrite, m_memRead, m_memWrite, m_aluSrc, m_aluOp} = '0;
    {m_rs1, m_rs2, m_rd, m_pc, m_imm, m_d1, m_d2, m_count} = '0;
  endtask

  function automatic bit model_hazard();
    return id_valid && m_valid != 0 && m_memRead != 0 && m_rd != 0 &&
           (m_rd == 32'(id_rs1) || m_rd == 32'(id_rs2));
  endfunction

  function automatic bit model_stall();
    return model_hazard() && !flush;
  endfunction

  function automatic int unsigned model_fwd(input logic [1:0] sel, input int unsigned q);
    if (sel == 2'd1) return mem_aluResult;
    if (sel == 2'd2) return wb_writeData;
    return q;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    bit hz;
    hz = model_hazard();
    if (hz && !flush && m_count < CNTMAX) m_count++;
    if (flush || hz) begin
      {m_valid, m_regWrite, m_memRead, m_memWrite, m_aluSrc, m_aluOp} = '0;
      {m_rs1, m_rs2, m_rd, m_pc, m_imm, m_d1, m_d2} = '0;
    end else begin
      m_valid    = id_valid;
      m_regWrite = id_valid ? id_regWrite : 0;
      m_memRead  = id_valid ? id_memRead : 0;
      m_memWrite = id_valid ? id_memWrite : 0;
      m_aluSrc   = id_valid ? id_aluSrc : 0;
      m_aluOp    = id_valid ? id_aluOp : 0;
      m_rs1      = id_valid ? id_rs1 : 0;
      m_rs2      = id_valid ? id_rs2 : 0;
      m_rd       = id_valid ? id_rd : 0;
      m_pc       = id_pc;
      m_imm      = id_imm;
      m_d1       = id_rs1_data;
      m_d2       = id_rs2_data;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {id_valid, id_regWrite, id_memRead, id_memWrite, id_aluSrc, flush} = '0;
    {id_pc, id_imm, id_rs1_data, id_rs2_data, mem_aluResult, wb_writeData} = '0;
    {id_rs1, id_rs2, id_rd, id_aluOp, df_mux1, df_mux2} = '0;
  endtask

  task automatic rand_inputs(input bit narrow);
    id_valid    = ($urandom_range(0, 7) != 0);
    id_regWrite = 1'($urandom);
    id_memRead  = ($urandom_range(0, 2) == 0);
    id_memWrite = 1'($urandom);
    id_aluSrc   = 1'($urandom);
    id_aluOp    = 4'($urandom);
    flush       = ($urandom_range(0, 7) == 0);
    id_pc       = $urandom;
    id_imm      = $urandom;
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    mem_aluResult = $urandom;
    wb_writeData  = $urandom;
    df_mux1 = 2'($urandom);
    df_mux2 = 2'($urandom);
    // Small register range makes load-use collisions frequent.
    id_rs1 = narrow ? RW'($urandom_range(0, 3)) : RW'($urandom);
    id_rs2 = narrow ? RW'($urandom_range(0, 3)) : RW'($urandom);
    id_rd  = narrow ? RW'($urandom_range(0, 3)) : RW'($urandom);
  endtask

  task automatic test_reset();
    logic [DW-1:0] all_or;
    rstN = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rand_inputs(1'b1);
      @(posedge clk);
      #1;
      all_or = ex_pc | ex_imm | 32'(stall_count) | 32'(ex_rd) | 32'(ex_rs1) | 32'(ex_rs2);
      tests_run++;
      if ({ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_aluSrc, ex_aluOp, stall} !== '0
          || all_or !== '0) begin
        tests_failed++;
        $display("FAIL reset_regs: got valid=%0b pc=%h cnt=%0d stall=%0b, want all zero",
                 ex_valid, ex_pc, stall_count, stall);
      end
    end
    clear_inputs();
    #1 rstN = 1'b1;
    #1;
    tests_run++;
    if (stall_count !== '0 || ex_valid !== 1'b0 || ex_opA !== '0) begin
      tests_failed++;
      $display("FAIL reset_release: got cnt=%0d valid=%0b opA=%h, want 0 0 0",
               stall_count, ex_valid, ex_opA);
    end
  endtask

  task automatic test_pass_through();
    clear_inputs();
    id_valid = 1; id_pc = 32'h100; id_rs1 = 3; id_rs1_data = 32'h11; df_mux1 = 0;
    tick();
    tests_run++;
    if (ex_pc !== 32'h100 || ex_rs1 !== 5'd3 || ex_opA !== 32'h11 || ex_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL pass_through: got pc=%h rs1=%0d opA=%h valid=%0b, want 100 3 11 1",
               ex_pc, ex_rs1, ex_opA, ex_valid);
    end
  endtask

  task automatic test_forwarding();
    logic [DW-1:0] exp_a [4];
    logic [DW-1:0] exp_s [3];
    exp_a[0] = 32'hAA; exp_a[1] = 32'h55; exp_a[2] = 32'h77; exp_a[3] = 32'hAA;
    exp_s[0] = 32'hBB; exp_s[1] = 32'h55; exp_s[2] = 32'h77;
    clear_inputs();
    id_valid = 1; id_rs1_data = 32'hAA; id_rs2_data = 32'hBB; id_aluSrc = 1; id_imm = 32'h4;
    tick();
    clear_inputs();
    mem_aluResult = 32'h55; wb_writeData = 32'h77;
    for (int s = 0; s < 4; s++) begin
      df_mux1 = 2'(s);
      #1;
      tests_run++;
      if (ex_opA !== exp_a[s]) begin
        tests_failed++;
        $display("FAIL fwd_opA sel=%0d: got %h, want %h", s, ex_opA, exp_a[s]);
      end
    end
    for (int s = 0; s < 3; s++) begin
      df_mux2 = 2'(s);
      #1;
      tests_run++;
      if (ex_opB !== 32'h4 || ex_storeData !== exp_s[s]) begin
        tests_failed++;
        $display("FAIL fwd_opB_store sel=%0d: got opB=%h store=%h, want 4 %h",
                 s, ex_opB, ex_storeData, exp_s[s]);
      end
    end
  endtask

  task automatic drive_lw();
    clear_inputs();
    id_valid = 1; id_memRead = 1; id_regWrite = 1; id_rd = 5; id_rs1 = 2;
  endtask

  task automatic drive_add();
    clear_inputs();
    id_valid = 1; id_regWrite = 1; id_rd = 6; id_rs1 = 5; id_rs2 = 1;
  endtask

  task automatic test_load_use();
    drive_lw();
    tick();
    drive_add();
    #1;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_stall: got %0b, want 1", stall);
    end
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || stall !== 1'b0 || stall_count !== CW'(1)) begin
      tests_failed++;
      $display("FAIL load_use_bubble: got valid=%0b stall=%0b cnt=%0d, want 0 0 1",
               ex_valid, stall, stall_count);
    end
    tick();
    tests_run++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_rs1 !== 5'd5 || ex_rs2 !== 5'd1) begin
      tests_failed++;
      $display("FAIL load_use_enter: got valid=%0b rd=%0d rs1=%0d rs2=%0d, want 1 6 5 1",
               ex_valid, ex_rd, ex_rs1, ex_rs2);
    end
  endtask

  task automatic test_flush_priority();
    drive_lw();
    tick();
    drive_add();
    flush = 1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_stall: got %0b, want 0", stall);
    end
    tick();
    tests_run++;
    if (ex_regWrite !== 1'b0 || ex_rd !== '0 || ex_valid !== 1'b0 || stall_count !== CW'(1))
    begin
      tests_failed++;
      $display("FAIL flush_bubble: got rw=%0b rd=%0d valid=%0b cnt=%0d, want 0 0 0 1",
               ex_regWrite, ex_rd, ex_valid, stall_count);
    end
    flush = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_inputs(1'b1);
      #1;
      tests_run++;
      if (stall !== model_stall() || ex_opA !== model_fwd(df_mux1, m_d1) ||
          ex_storeData !== model_fwd(df_mux2, m_d2) ||
          ex_opB !== (m_aluSrc != 0 ? m_imm : model_fwd(df_mux2, m_d2))) begin
        tests_failed++;
        $display("FAIL rand_comb %0d: got stall=%0b opA=%h opB=%h st=%h, want %0b %h %h %h",
                 i, stall, ex_opA, ex_opB, ex_storeData, model_stall(),
                 model_fwd(df_mux1, m_d1),
                 (m_aluSrc != 0 ? m_imm : model_fwd(df_mux2, m_d2)),
                 model_fwd(df_mux2, m_d2));
      end
      tick();
      tests_run++;
      if (ex_valid !== m_valid[0] || ex_regWrite !== m_regWrite[0] ||
          ex_memRead !== m_memRead[0] || ex_memWrite !== m_memWrite[0] ||
          ex_aluSrc !== m_aluSrc[0] || ex_aluOp !== m_aluOp[3:0] ||
          ex_rs1 !== m_rs1[RW-1:0] || ex_rs2 !== m_rs2[RW-1:0] || ex_rd !== m_rd[RW-1:0] ||
          ex_pc !== m_pc || ex_imm !== m_imm || stall_count !== m_count[CW-1:0]) begin
        tests_failed++;
        $display("FAIL rand_regs %0d: got v=%0b rd=%0d pc=%h cnt=%0d, want %0d %0d %h %0d",
                 i, ex_valid, ex_rd, ex_pc, stall_count, m_valid, m_rd, m_pc, m_count);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive_lw();
      tick();
      drive_add();
      tick();
      tests_run++;
      if (stall_count !== m_count[CW-1:0]) begin
        tests_failed++;
        $display("FAIL sat_step %0d: got %0d, want %0d", i, stall_count, m_count);
      end
    end
    tests_run++;
    if (stall_count !== CW'(15)) begin
      tests_failed++;
      $display("FAIL sat_final: got %0d, want 15", stall_count);
    end
  endtask

  task automatic test_async_reset();
    drive_lw();
    tick();
    #2 rstN = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (ex_valid !== 1'b0 || ex_memRead !== 1'b0 || stall_count !== '0 || ex_rd !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got valid=%0b rd=%0d cnt=%0d, want 0 0 0",
               ex_valid, ex_rd, stall_count);
    end
    #2 rstN = 1'b1;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_pass_through();
    test_forwarding();
    test_load_use();
    test_flush_priority();
    test_random();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
